// File: rtl/gf180_ram_pkg.sv
// Shared types and constants for the gf180mcu 512x8 SRAM access path.
//   RAM_AW / RAM_DW : macro address / data widths
//   PRIO_RR / PRIO_FIXED : arbitration mode selectors
//   ram_req_t : one requester's access payload
//   rd_tag_t  : in-flight read tag (valid + returning port)
package gf180_ram_pkg;

    localparam int unsigned RAM_AW = 9;
    localparam int unsigned RAM_DW = 8;

    localparam int unsigned PRIO_RR    = 0;
    localparam int unsigned PRIO_FIXED = 1;

    typedef struct packed {
        logic              we;
        logic [RAM_AW-1:0] addr;
        logic [RAM_DW-1:0] wdata;
        logic [RAM_DW-1:0] wmask;
    } ram_req_t;

    typedef struct packed {
        logic vld;
        logic port;
    } rd_tag_t;

endpackage

// File: rtl/gf180_ram_rr_arb2.sv
// Two-input arbiter with a round-robin pointer or fixed priority.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset; blocks all grants while high
//   req  : request vector, bit i = port i
//   gnt  : one-hot grant, combinational from req in the same cycle
module gf180_ram_rr_arb2
    import gf180_ram_pkg::*;
#(
    parameter int unsigned PRIORITY_MODE = PRIO_RR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // ptr = 0 prefers port 0, ptr = 1 prefers port 1
    logic ptr;
    logic ptr_nxt;

    // Grant selection; the pointer only moves on a contested round-robin grant
    always_comb begin
        gnt     = 2'b00;
        ptr_nxt = ptr;
        if (!rst) begin
            case (req)
                2'b01: gnt = 2'b01;
                2'b10: gnt = 2'b10;
                2'b11: begin
                    if (PRIORITY_MODE == PRIO_FIXED) begin
                        gnt = 2'b01;
                    end else begin
                        gnt     = ptr ? 2'b10 : 2'b01;
                        ptr_nxt = ~ptr;
                    end
                end
                default: gnt = 2'b00;
            endcase
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/gf180_ram_512x8_arbiter.sv
// Shares one gf180mcu 512x8 SRAM macro between the management CPU (port 0)
// and the housekeeping/DMA path (port 1). One access per cycle; macro pins
// are driven combinationally from the winner, reads return two cycles later.
// Ports:
//   wb_clk_i, wb_rst_i               : clock, synchronous active-high reset
//   reqN_i/weN_i/addrN_i/wdataN_i/wmaskN_i : port N request payload
//   gntN_o                           : port N accepted this cycle (combinational)
//   rvalidN_o/rdataN_o               : port N read return (pulse / held data)
//   ram_cen_o/ram_gwen_o/ram_wen_o   : macro controls, active low
//   ram_a_o/ram_d_o/ram_q_i          : macro address, write data, read data
module gf180_ram_512x8_arbiter
    import gf180_ram_pkg::*;
#(
    parameter int unsigned PRIORITY_MODE = PRIO_RR,
    parameter int unsigned AW            = RAM_AW,
    parameter int unsigned DW            = RAM_DW
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,

    input  logic          req0_i,
    input  logic          we0_i,
    input  logic [AW-1:0] addr0_i,
    input  logic [DW-1:0] wdata0_i,
    input  logic [DW-1:0] wmask0_i,
    output logic          gnt0_o,
    output logic          rvalid0_o,
    output logic [DW-1:0] rdata0_o,

    input  logic          req1_i,
    input  logic          we1_i,
    input  logic [AW-1:0] addr1_i,
    input  logic [DW-1:0] wdata1_i,
    input  logic [DW-1:0] wmask1_i,
    output logic          gnt1_o,
    output logic          rvalid1_o,
    output logic [DW-1:0] rdata1_o,

    output logic          ram_cen_o,
    output logic          ram_gwen_o,
    output logic [DW-1:0] ram_wen_o,
    output logic [AW-1:0] ram_a_o,
    output logic [DW-1:0] ram_d_o,
    input  logic [DW-1:0] ram_q_i
);

    ram_req_t      req_p0;
    ram_req_t      req_p1;
    ram_req_t      win;
    logic [1:0]    gnt;
    logic          granted;

    logic [AW-1:0] a_q;
    logic [DW-1:0] d_q;

    rd_tag_t       tag_q;
    logic          rvalid0_q;
    logic          rvalid1_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    // Pack each port's request payload
    assign req_p0 = '{we: we0_i, addr: addr0_i, wdata: wdata0_i, wmask: wmask0_i};
    assign req_p1 = '{we: we1_i, addr: addr1_i, wdata: wdata1_i, wmask: wmask1_i};

    gf180_ram_rr_arb2 #(
        .PRIORITY_MODE (PRIORITY_MODE)
    ) u_arb (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .req ({req1_i, req0_i}),
        .gnt (gnt)
    );

    assign gnt0_o  = gnt[0];
    assign gnt1_o  = gnt[1];
    assign granted = |gnt;
    assign win     = gnt[1] ? req_p1 : req_p0;

    // Macro drive; address and data park on the last granted values when idle
    always_comb begin
        ram_cen_o  = 1'b1;
        ram_gwen_o = 1'b1;
        ram_wen_o  = '1;
        ram_a_o    = a_q;
        ram_d_o    = d_q;
        if (granted) begin
            ram_cen_o  = 1'b0;
            ram_gwen_o = ~win.we;
            ram_a_o    = win.addr;
            ram_d_o    = win.wdata;
            if (win.we) begin
                ram_wen_o = ~win.wmask;
            end
        end
    end

    // Parking registers for macro address/data
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            a_q <= '0;
            d_q <= '0;
        end else if (granted) begin
            a_q <= win.addr;
            d_q <= win.wdata;
        end
    end

    // Read tag: marks which port owns the Q that appears in the next cycle
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tag_q <= '0;
        end else begin
            tag_q.vld  <= granted & ~win.we;
            tag_q.port <= gnt[1];
        end
    end

    // Read return: capture Q into the tagged port only, pulse its rvalid
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= tag_q.vld & ~tag_q.port;
            rvalid1_q <= tag_q.vld &  tag_q.port;
            if (tag_q.vld && !tag_q.port) begin
                rdata0_q <= ram_q_i;
            end
            if (tag_q.vld && tag_q.port) begin
                rdata1_q <= ram_q_i;
            end
        end
    end

    assign rvalid0_o = rvalid0_q;
    assign rvalid1_o = rvalid1_q;
    assign rdata0_o  = rdata0_q;
    assign rdata1_o  = rdata1_q;

endmodule

// File: tb/tb_gf180_ram_512x8_arbiter.sv
// Self-checking bench: behavioural macro model, shadow memory and per-port
// read scoreboards, plus a fixed-priority instance for the starvation case.
module tb_gf180_ram_512x8_arbiter;
    import gf180_ram_pkg::*;

    typedef struct {
        int data;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    logic       started = 1'b0;

    // Round-robin instance signals
    logic       req0, we0, req1, we1;
    logic [8:0] addr0, addr1;
    logic [7:0] wdata0, wmask0, wdata1, wmask1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata0, rdata1;
    logic       ram_cen, ram_gwen;
    logic [7:0] ram_wen, ram_d, ram_q;
    logic [8:0] ram_a;

    // Fixed-priority instance signals
    logic       f_req0, f_req1;
    logic       f_gnt0, f_gnt1, f_rvalid0, f_rvalid1;
    logic [7:0] f_rdata0, f_rdata1, f_wen, f_d;
    logic [7:0] f_q = 8'h00;
    logic [8:0] f_a;
    logic       f_cen, f_gwen;

    logic [7:0] mem    [0:511];
    logic [7:0] shadow [0:511];
    exp_t       q0[$];
    exp_t       q1[$];
    logic [7:0] exp_rd0 = 8'h00;
    logic [7:0] exp_rd1 = 8'h00;
    logic [8:0] last_a = 9'h000;
    logic [7:0] last_d = 8'h00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gf180_ram_512x8_arbiter #(.PRIORITY_MODE(PRIO_RR)) u_dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0), .wmask0_i(wmask0),
        .gnt0_o(gnt0), .rvalid0_o(rvalid0), .rdata0_o(rdata0),
        .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1), .wmask1_i(wmask1),
        .gnt1_o(gnt1), .rvalid1_o(rvalid1), .rdata1_o(rdata1),
        .ram_cen_o(ram_cen), .ram_gwen_o(ram_gwen), .ram_wen_o(ram_wen),
        .ram_a_o(ram_a), .ram_d_o(ram_d), .ram_q_i(ram_q)
    );

    gf180_ram_512x8_arbiter #(.PRIORITY_MODE(PRIO_FIXED)) u_fix (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .req0_i(f_req0), .we0_i(1'b0), .addr0_i(9'd1), .wdata0_i(8'h00), .wmask0_i(8'h00),
        .gnt0_o(f_gnt0), .rvalid0_o(f_rvalid0), .rdata0_o(f_rdata0),
        .req1_i(f_req1), .we1_i(1'b0), .addr1_i(9'd2), .wdata1_i(8'h00), .wmask1_i(8'h00),
        .gnt1_o(f_gnt1), .rvalid1_o(f_rvalid1), .rdata1_o(f_rdata1),
        .ram_cen_o(f_cen), .ram_gwen_o(f_gwen), .ram_wen_o(f_wen),
        .ram_a_o(f_a), .ram_d_o(f_d), .ram_q_i(f_q)
    );

    // Behavioural 512x8 macro: masked write or read into Q on a selected edge
    always @(posedge clk) begin
        if (!ram_cen) begin
            if (!ram_gwen) mem[ram_a] <= (mem[ram_a] & ram_wen) | (ram_d & ~ram_wen);
            else           ram_q <= mem[ram_a];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic drv0(input logic r, input logic w, input logic [8:0] a,
                        input logic [7:0] d, input logic [7:0] m);
        req0 = r; we0 = w; addr0 = a; wdata0 = d; wmask0 = m;
    endtask

    task automatic drv1(input logic r, input logic w, input logic [8:0] a,
                        input logic [7:0] d, input logic [7:0] m);
        req1 = r; we1 = w; addr1 = a; wdata1 = d; wmask1 = m;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drv0(1'b0, 1'b0, 9'd0, 8'h00, 8'h00);
        drv1(1'b0, 1'b0, 9'd0, 8'h00, 8'h00);
        repeat (n) tick();
    endtask

    // Monitor: macro pin checks, shadow update, scoreboard push/pop
    always @(negedge clk) begin
        exp_t       e;
        logic       w;
        logic [8:0] a;
        logic [7:0] d, m, exp_wen;
        logic       exp_gwen;
        if (started) begin
            if (rvalid0) begin
                if (q0.size() == 0) chk("rv0_spurious", 32'(rvalid0), 32'd0);
                else begin
                    e = q0.pop_front();
                    chk("rd0_data", 32'(rdata0), 32'(e.data));
                    chk("rd0_lat", 32'(cyc), 32'(e.cyc + 2));
                    exp_rd0 = 8'(e.data);
                end
            end else if (!rst) chk("rd0_hold", 32'(rdata0), 32'(exp_rd0));
            if (rvalid1) begin
                if (q1.size() == 0) chk("rv1_spurious", 32'(rvalid1), 32'd0);
                else begin
                    e = q1.pop_front();
                    chk("rd1_data", 32'(rdata1), 32'(e.data));
                    chk("rd1_lat", 32'(cyc), 32'(e.cyc + 2));
                    exp_rd1 = 8'(e.data);
                end
            end else if (!rst) chk("rd1_hold", 32'(rdata1), 32'(exp_rd1));

            chk("gnt_onehot", 32'(gnt0 & gnt1), 32'd0);
            chk("gnt0_noreq", 32'(gnt0 & ~req0), 32'd0);
            chk("gnt1_noreq", 32'(gnt1 & ~req1), 32'd0);
            if (rst) chk("rst_gnt", 32'({gnt1, gnt0}), 32'd0);

            if (gnt0 || gnt1) begin
                w = gnt1 ? we1 : we0;
                a = gnt1 ? addr1 : addr0;
                d = gnt1 ? wdata1 : wdata0;
                m = gnt1 ? wmask1 : wmask0;
                exp_gwen = 1'(~w);
                exp_wen  = w ? 8'(~m) : 8'hFF;
                chk("cen_act", 32'(ram_cen), 32'd0);
                chk("gwen", 32'(ram_gwen), 32'(exp_gwen));
                chk("wen", 32'(ram_wen), 32'(exp_wen));
                chk("addr", 32'(ram_a), 32'(a));
                chk("wdata", 32'(ram_d), 32'(d));
                if (w) shadow[a] = (shadow[a] & 8'(~m)) | (d & m);
                else if (gnt1) q1.push_back('{data: int'(shadow[a]), cyc: cyc});
                else q0.push_back('{data: int'(shadow[a]), cyc: cyc});
                last_a = a;
                last_d = d;
            end else begin
                chk("cen_idle", 32'(ram_cen), 32'd1);
                chk("gwen_idle", 32'(ram_gwen), 32'd1);
                chk("wen_idle", 32'(ram_wen), 32'hFF);
                if (!rst) begin
                    chk("a_hold", 32'(ram_a), 32'(last_a));
                    chk("d_hold", 32'(ram_d), 32'(last_d));
                end
            end

            // A reset edge drops everything in flight and clears the registers
            if (rst) begin
                q0.delete();
                q1.delete();
                exp_rd0 = 8'h00;
                exp_rd1 = 8'h00;
                last_a  = 9'h000;
                last_d  = 8'h00;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem[i]    = 8'h00;
            shadow[i] = 8'h00;
        end
        ram_q = 8'h00;
        rst = 1'b1;
        f_req0 = 1'b1;
        f_req1 = 1'b1;
        drv0(1'b1, 1'b0, 9'd0, 8'h00, 8'h00);
        drv1(1'b1, 1'b0, 9'd0, 8'h00, 8'h00);
        tick();
        started = 1'b1;

        // Reset with both ports requesting
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_gnt0", 32'(gnt0), 32'd0);
            chk("rst_gnt1", 32'(gnt1), 32'd0);
            chk("rst_cen", 32'(ram_cen), 32'd1);
            chk("rst_wen", 32'(ram_wen), 32'hFF);
            chk("rst_rv", 32'({rvalid1, rvalid0}), 32'd0);
            chk("rst_rdata", 32'({rdata1, rdata0}), 32'd0);
            chk("rst_fgnt", 32'({f_gnt1, f_gnt0}), 32'd0);
            tick();
        end
        rst = 1'b0;
        f_req0 = 1'b0;
        f_req1 = 1'b0;
        idle(1);

        // Port 0 write then read of the top address
        drv0(1'b1, 1'b1, 9'h1FF, 8'hA5, 8'hFF);
        @(negedge clk); chk("wr_gnt0", 32'(gnt0), 32'd1);
        tick();
        drv0(1'b1, 1'b0, 9'h1FF, 8'h00, 8'h00);
        @(negedge clk); chk("rd_gnt0", 32'(gnt0), 32'd1);
        tick();
        drv0(1'b0, 1'b0, 9'd0, 8'h00, 8'h00);
        @(negedge clk); chk("rd_rv0_n1", 32'(rvalid0), 32'd0);
        tick();
        @(negedge clk);
        chk("rd_rv0_n2", 32'(rvalid0), 32'd1);
        chk("rd_data0", 32'(rdata0), 32'hA5);
        chk("rd_rdata1", 32'(rdata1), 32'h00);
        idle(2);

        // Bit-mask write on port 1, then a zero-mask write on port 0
        drv1(1'b1, 1'b1, 9'd3, 8'hFF, 8'hFF); tick();
        drv1(1'b1, 1'b1, 9'd3, 8'h00, 8'h0F); tick();
        drv1(1'b0, 1'b0, 9'd0, 8'h00, 8'h00);
        drv0(1'b1, 1'b1, 9'd3, 8'hAA, 8'h00);
        @(negedge clk); chk("m0_wen", 32'(ram_wen), 32'hFF);
        tick();
        drv0(1'b0, 1'b0, 9'd0, 8'h00, 8'h00);
        drv1(1'b1, 1'b0, 9'd3, 8'h00, 8'h00); tick();
        drv1(1'b0, 1'b0, 9'd0, 8'h00, 8'h00); tick();
        @(negedge clk);
        chk("mask_rv1", 32'(rvalid1), 32'd1);
        chk("mask_data", 32'(rdata1), 32'hF0);
        idle(2);

        // Preload the contention addresses
        drv0(1'b1, 1'b1, 9'd10, 8'h11, 8'hFF); tick();
        drv0(1'b0, 1'b0, 9'd0, 8'h00, 8'h00);
        drv1(1'b1, 1'b1, 9'd20, 8'h22, 8'hFF); tick();
        idle(1);

        // Round-robin contention: both read continuously
        for (int k = 0; k < 6; k++) begin
            drv0(1'b1, 1'b0, 9'd10, 8'h00, 8'h00);
            drv1(1'b1, 1'b0, 9'd20, 8'h00, 8'h00);
            @(negedge clk);
            chk("rr_gnt0", 32'(gnt0), 32'((k % 2) == 0));
            chk("rr_gnt1", 32'(gnt1), 32'((k % 2) == 1));
            if (k >= 2) begin
                chk("rr_rv0", 32'(rvalid0), 32'((k % 2) == 0));
                chk("rr_rv1", 32'(rvalid1), 32'((k % 2) == 1));
            end
            tick();
        end
        idle(3);

        // Fixed priority: port 1 starves until port 0 releases
        f_req0 = 1'b1;
        f_req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("fx_gnt0", 32'(f_gnt0), 32'd1);
            chk("fx_gnt1", 32'(f_gnt1), 32'd0);
            tick();
        end
        f_req0 = 1'b0;
        @(negedge clk);
        chk("fx_rel_gnt1", 32'(f_gnt1), 32'd1);
        chk("fx_rel_gnt0", 32'(f_gnt0), 32'd0);
        tick();
        f_req1 = 1'b0;
        idle(1);

        // Mid-read reset: move pointer to port 1, grant a port 1 read, then reset
        drv0(1'b1, 1'b0, 9'd10, 8'h00, 8'h00);
        drv1(1'b1, 1'b0, 9'd20, 8'h00, 8'h00);
        @(negedge clk); chk("pre_gnt0", 32'(gnt0), 32'd1);
        tick();
        drv0(1'b0, 1'b0, 9'd0, 8'h00, 8'h00);
        @(negedge clk); chk("pre_gnt1", 32'(gnt1), 32'd1);
        tick();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_no_rv1", 32'(rvalid1), 32'd0);
            tick();
        end
        drv0(1'b1, 1'b0, 9'd10, 8'h00, 8'h00);
        drv1(1'b1, 1'b0, 9'd20, 8'h00, 8'h00);
        @(negedge clk);
        chk("ptr_rst_gnt0", 32'(gnt0), 32'd1);
        chk("ptr_rst_gnt1", 32'(gnt1), 32'd0);
        tick();
        drv0(1'b0, 1'b0, 9'd0, 8'h00, 8'h00);
        @(negedge clk); chk("ptr_rst_next1", 32'(gnt1), 32'd1);
        tick();
        idle(4);

        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gf180_ram_512x8_arbiter.md
Name: gf180_ram_512x8_arbiter

Overview:
- Shares one gf180mcu 512x8 SRAM macro between two requesters. Port 0 is the management CPU path; port 1 is the housekeeping/DMA path.
- Arbitrates one access per cycle and drives the macro's active-low CEN/GWEN/WEN pins directly.
- Captures macro Q into a per-port read-data register and returns it with a valid strobe.
- Sits between the bus adapters and the RAM wrapper.

Parameters:
- PRIORITY_MODE, 0, 0 = round-robin between ports; 1 = fixed priority, port 0 always wins.
- AW, 9, address width; fixed to macro depth 512. Other values are unsupported.
- DW, 8, data width; fixed to macro width 8.

Ports:
- wb_clk_i  input  1  single clock; also drives macro CLK
- wb_rst_i  input  1  synchronous, active-high reset
- req0_i  input  1  port 0 access request
- we0_i  input  1  port 0 write (1) / read (0)
- addr0_i  input  9  port 0 address
- wdata0_i  input  8  port 0 write data
- wmask0_i  input  8  port 0 bit write mask, 1 = write bit
- gnt0_o  output  1  port 0 request accepted this cycle
- rvalid0_o  output  1  port 0 read data valid, 1-cycle pulse
- rdata0_o  output  8  port 0 read data, held until next port 0 read return
- req1_i, we1_i, addr1_i, wdata1_i, wmask1_i, gnt1_o, rvalid1_o, rdata1_o: same widths and meaning for port 1
- ram_cen_o  output  1  macro CEN, active low
- ram_gwen_o  output  1  macro GWEN, active low
- ram_wen_o  output  8  macro WEN, active low per bit
- ram_a_o  output  9  macro address
- ram_d_o  output  8  macro write data
- ram_q_i  input  8  macro read data

Behaviour:
- Reset values (wb_rst_i = 1 at a clock edge):
  - gnt*=0, rvalid*=0, rdata*=8'h00.
  - ram_cen_o=1, ram_gwen_o=1, ram_wen_o=8'hFF, ram_a_o=0, ram_d_o=0.
  - RR pointer selects port 0 as next preferred.
- While wb_rst_i is high, all grants are blocked and ram_cen_o is forced to 1.
- Grant is combinational in cycle N: gnt_o asserts in the same cycle as req_i when that port wins. At most one gnt per cycle.
- A requester holds req/we/addr/wdata/wmask stable until it sees gnt. It may drop req before grant with no side effect.
- Arbitration:
  - One requester: it wins.
  - Both requesting, PRIORITY_MODE=0: the port named by the RR pointer wins. The pointer then flips to the other port. The pointer updates only on a contested grant.
  - Both requesting, PRIORITY_MODE=1: port 0 wins. Port 1 may starve; this is accepted.
- Macro drive in grant cycle N (combinational from the winner):
  - ram_cen_o=0, ram_a_o=addr, ram_d_o=wdata.
  - ram_gwen_o=~we.
  - ram_wen_o=~wmask for a write; 8'hFF for a read.
  - No grant: ram_cen_o=1, ram_gwen_o=1, ram_wen_o=8'hFF; A and D hold their last value.
- Read pipeline:
  - Macro samples at edge ending N; Q is valid during N+1.
  - A registered tag (valid bit + port id) is set at edge ending N for read grants only.
  - At edge ending N+1, the tagged port's rdata register loads ram_q_i, and rvalid pulses in N+2.
  - Read latency is 2 cycles, fully pipelined: back-to-back reads, alternating or same-port, give back-to-back rvalid.
- Writes produce no rvalid. Write completes at edge ending N.
- A read of an address written in the previous cycle returns the new data; the macro guarantees this, and no forwarding is needed.
- rdata of the non-returning port is unchanged.
- wmask=0 write: still a granted macro cycle with all WEN bits high. Memory is unchanged and no rvalid is generated.
- Reset mid-operation: any in-flight read tag is cleared, so no rvalid follows a reset edge. The macro contents are undefined-by-spec but untouched.
- Address wrap: none; addresses are 9-bit, 0..511 only.

Decomposition:
- Shared package gf180_ram_pkg:
  - RAM_AW=9, RAM_DW=8.
  - Typedef ram_req_t {we, addr, wdata, wmask}.
  - Constants PRIO_RR=0, PRIO_FIXED=1.
- One sub-module gf180_ram_rr_arb2: 2-input arbiter with RR pointer and PRIORITY_MODE, grant one-hot out.
- The top instantiates it plus the macro-drive mux and the read-return pipeline. The RAM wrapper is instantiated one level up, not inside this block.

Test Plan:
- Reset check: assert wb_rst_i with req0/req1 high -> gnt*=0, ram_cen_o=1, ram_wen_o=8'hFF, rvalid*=0 for the full reset duration.
- Single-port write then read:
  - Port 0 writes 8'hA5, mask 8'hFF, to addr 9'h1FF.
  - Port 0 reads 9'h1FF next cycle -> rvalid0 two cycles after grant, rdata0=8'hA5, rdata1 unchanged.
- Bit-mask write:
  - Write 8'hFF to addr 3, mask 8'hFF.
  - Then write 8'h00 to addr 3, mask 8'h0F.
  - Read addr 3 -> 8'hF0.
- Contention, PRIORITY_MODE=0:
  - req0 and req1 both read continuously for 6 cycles.
  - Expect grants 0,1,0,1,0,1 and rvalid0/rvalid1 alternating starting 2 cycles after the first grant.
  - Each port's data matches its preloaded addresses (port 0 addr 10 -> 8'h11, port 1 addr 20 -> 8'h22).
- Contention, PRIORITY_MODE=1: both requesting for 4 cycles -> gnt0 every cycle and gnt1 never. Release req0 -> gnt1 in the same cycle.
- Reset mid-read: grant a port 1 read, then assert wb_rst_i on the next edge -> no rvalid1 ever appears. The RR pointer returns to port 0 preferred.
